// File: rtl/alu_core.sv
// Single-cycle registered ALU: one operation accepted every clock edge.
// The result and zero flag are both registered from the same next-state value.
module alu_core #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic [3:0]       alu_ctrl,
   output logic [WIDTH-1:0] alu_result,
   output logic             zero_flag
);

   // No handshake: inputs are sampled on every rising edge and the result
   // for that edge is valid on the outputs until the following edge.

   logic [WIDTH-1:0] r_result;
   logic             r_zero;
   logic [WIDTH-1:0] w_next;
   logic [4:0]       w_shamt;
   logic             w_slt;
   logic             w_sltu;

   assign w_shamt = in2[4:0];
   assign w_slt   = $signed(in1) < $signed(in2);
   assign w_sltu  = in1 < in2;

   always_comb begin
      w_next = '0;
      case (alu_ctrl)
         4'b0000: w_next = in1 + in2;
         4'b0001: w_next = in1 - in2;
         4'b0010: w_next = in1 & in2;
         4'b0011: w_next = in1 | in2;
         4'b0100: w_next = in1 ^ in2;
         4'b0101: w_next = in1 << w_shamt;
         4'b0110: w_next = in1 >> w_shamt;
         4'b0111: w_next = $unsigned($signed(in1) >>> w_shamt);
         4'b1000: w_next = {{(WIDTH-1){1'b0}}, w_slt};
         4'b1001: w_next = {{(WIDTH-1){1'b0}}, w_sltu};
         default: w_next = '0;
      endcase
   end

   // Reset wins over the operation sampled on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_result <= '0;
         r_zero   <= 1'b1;
      end else begin
         r_result <= w_next;
         r_zero   <= (w_next == '0);
      end
   end

   assign alu_result = r_result;
   assign zero_flag  = r_zero;

endmodule

// File: tb/tb_alu_core.sv
// Bench for alu_core: randomized operations checked against an arithmetic model,
// plus directed vectors carrying hand-computed expected values.
module tb_alu_core;

   localparam int W = 32;

   logic         clk;
   logic         rst;
   logic [W-1:0] in1;
   logic [W-1:0] in2;
   logic [3:0]   alu_ctrl;
   logic [W-1:0] alu_result;
   logic         zero_flag;

   int n_checks = 0;
   int n_pass   = 0;

   logic [W:0]   exp_q[$];   // {zero, result} from the model
   logic [W+1:0] lit_q[$];   // {valid, zero, result} hand-computed literal

   alu_core #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in1        (in1),
      .in2        (in2),
      .alu_ctrl   (alu_ctrl),
      .alu_result (alu_result),
      .zero_flag  (zero_flag)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL timeout: run did not complete, actual=running required=done");
      n_checks++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // reference model: plain integer arithmetic on 64-bit values
   function automatic logic [W:0] model(input logic r, input logic [W-1:0] a,
                                        input logic [W-1:0] b, input logic [3:0] c);
      longint unsigned ua, ub, m;
      longint          sa, sb, p, q;
      int              sh;
      logic [W-1:0]    y;
      ua = longint'(a);
      ub = longint'(b);
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      m  = 64'd1 << 32;
      sh = int'(b % 32);
      p  = longint'(64'd1 << sh);
      y  = '0;
      if (r) return {1'b1, {W{1'b0}}};
      case (c)
         4'd0: y = 32'((ua + ub) % m);
         4'd1: y = 32'((ua + m - ub) % m);
         4'd2: y = a & b;
         4'd3: y = a | b;
         4'd4: y = a ^ b;
         4'd5: y = 32'((ua * longint'(p)) % m);
         4'd6: y = 32'(ua / longint'(p));
         4'd7: begin
            if (sa >= 0) q = sa / p;
            else q = -((-sa + p - 1) / p);
            y = 32'(q);
         end
         4'd8: y = (sa < sb) ? 32'd1 : 32'd0;
         4'd9: y = (ua < ub) ? 32'd1 : 32'd0;
         default: y = '0;
      endcase
      return {(y == '0), y};
   endfunction

   // driver: inputs change on the falling edge, sampled at the next rising edge
   task automatic do_op(input logic r, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] c, input bit has_lit,
                        input logic [W-1:0] lres, input logic lz, input bit glitch);
      @(negedge clk);
      rst      = r;
      in1      = a;
      in2      = b;
      alu_ctrl = c;
      exp_q.push_back(model(r, a, b, c));
      lit_q.push_back({has_lit, lz, lres});
      if (glitch) begin
         #1 rst = 1'b1;
         #1 rst = r;
      end
   endtask

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
   endtask

   // scoreboard compare, one cycle after each driven operation
   initial begin
      logic [W:0]   e;
      logic [W+1:0] l;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            l = lit_q.pop_front();
            check("model_result", alu_result, e[W-1:0]);
            check("model_zero", {31'b0, zero_flag}, {31'b0, e[W]});
            if (l[W+1]) begin
               check("lit_result", alu_result, l[W-1:0]);
               check("lit_zero", {31'b0, zero_flag}, {31'b0, l[W]});
            end
         end
      end
   end

   initial begin
      logic [W-1:0] a, b;
      logic [3:0]   c;
      logic         r;
      rst = 1'b1; in1 = '0; in2 = '0; alu_ctrl = '0;

      // reset with live inputs
      do_op(1'b1, 32'd5, 32'd6, 4'd0, 1'b1, 32'd0, 1'b1, 1'b0);
      do_op(1'b1, 32'd5, 32'd6, 4'd1, 1'b1, 32'd0, 1'b1, 1'b0);

      // basic ops on 5 and 6
      do_op(1'b0, 32'd5, 32'd6, 4'd0, 1'b1, 32'd11,         1'b0, 1'b0);
      do_op(1'b0, 32'd5, 32'd6, 4'd1, 1'b1, 32'hFFFF_FFFF,  1'b0, 1'b0);
      do_op(1'b0, 32'd5, 32'd6, 4'd2, 1'b1, 32'd4,          1'b0, 1'b0);
      do_op(1'b0, 32'd5, 32'd6, 4'd3, 1'b1, 32'd7,          1'b0, 1'b0);
      do_op(1'b0, 32'd5, 32'd6, 4'd4, 1'b1, 32'd3,          1'b0, 1'b0);
      do_op(1'b0, 32'd5, 32'd6, 4'd5, 1'b1, 32'd320,        1'b0, 1'b0);
      do_op(1'b0, 32'd5, 32'd6, 4'd6, 1'b1, 32'd0,          1'b1, 1'b0);
      do_op(1'b0, 32'd5, 32'd6, 4'd7, 1'b1, 32'd0,          1'b1, 1'b0);
      do_op(1'b0, 32'd5, 32'd6, 4'd8, 1'b1, 32'd1,          1'b0, 1'b0);

      // sign-sensitive shifts and compares
      do_op(1'b0, 32'h8000_0000, 32'd4, 4'd7, 1'b1, 32'hF800_0000, 1'b0, 1'b0);
      do_op(1'b0, 32'h8000_0000, 32'd4, 4'd6, 1'b1, 32'h0800_0000, 1'b0, 1'b0);
      do_op(1'b0, 32'h8000_0000, 32'd1, 4'd8, 1'b1, 32'd1,         1'b0, 1'b0);
      do_op(1'b0, 32'h8000_0000, 32'd1, 4'd9, 1'b1, 32'd0,         1'b1, 1'b0);

      // wrap, shift amount of 32, undefined code
      do_op(1'b0, 32'hFFFF_FFFF, 32'd1, 4'd0, 1'b1, 32'd0, 1'b1, 1'b0);
      do_op(1'b0, 32'd7,  32'd7,  4'd1,  1'b1, 32'd0, 1'b1, 1'b0);
      do_op(1'b0, 32'd5,  32'd32, 4'd5,  1'b1, 32'd5, 1'b0, 1'b0);
      do_op(1'b0, 32'd5,  32'd6,  4'd15, 1'b1, 32'd0, 1'b1, 1'b0);

      // reset mid-stream, then recovery; a between-edge rst pulse is ignored
      do_op(1'b1, 32'd5, 32'd6, 4'd0, 1'b1, 32'd0,  1'b1, 1'b0);
      do_op(1'b0, 32'd5, 32'd6, 4'd0, 1'b1, 32'd11, 1'b0, 1'b0);
      do_op(1'b0, 32'd9, 32'd6, 4'd0, 1'b1, 32'd15, 1'b0, 1'b1);

      // randomized traffic with biased operands
      for (int i = 0; i < 2000; i++) begin
         case ($urandom_range(0, 3))
            0: a = $urandom();
            1: a = 32'h8000_0000 | $urandom_range(0, 15);
            2: a = $urandom_range(0, 8);
            default: a = 32'hFFFF_FFFF - $urandom_range(0, 3);
         endcase
         case ($urandom_range(0, 3))
            0: b = $urandom();
            1: b = a;
            2: b = $urandom_range(0, 40);
            default: b = 32'hFFFF_FFFF - $urandom_range(0, 3);
         endcase
         c = 4'($urandom_range(0, 15));
         r = ($urandom_range(0, 31) == 0);
         do_op(r, a, b, c, 1'b0, 32'd0, 1'b0, ($urandom_range(0, 15) == 0));
      end

      repeat (3) @(negedge clk);
      n_checks++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL drain: actual=%0d pending required=0 pending", exp_q.size());
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
